// File: rtl/target_frame_ctrl.sv
// Frame sequencer between the marker detector and pose logic: restarts the detector per frame,
// snapshots its results at frame end, tracks per-target lock and hands frames out via valid/ready.
// Build option TARGET_AVG_EN: locked, valid targets are smoothed as (previous + new) >> 1.
module target_frame_ctrl #(
  parameter int NUM_TARGETS   = 4,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int LOCK_FRAMES   = 3,
  parameter int XW            = $clog2(SCREEN_WIDTH),
  parameter int YW            = $clog2(SCREEN_HEIGHT) + 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic [XW-1:0]             hcount_in,
  input  logic [YW-1:0]             vcount_in,
  input  logic [NUM_TARGETS*XW-1:0] det_x_in,
  input  logic [NUM_TARGETS*YW-1:0] det_y_in,
  input  logic [NUM_TARGETS*YW-1:0] det_diam_in,
  input  logic [NUM_TARGETS-1:0]    det_valid_in,
  output logic                      det_start_out,
  output logic [NUM_TARGETS*XW-1:0] tgt_x_out,
  output logic [NUM_TARGETS*YW-1:0] tgt_y_out,
  output logic [NUM_TARGETS*YW-1:0] tgt_diam_out,
  output logic [NUM_TARGETS-1:0]    tgt_valid_out,
  output logic [NUM_TARGETS-1:0]    tgt_lock_out,
  output logic                      out_valid_out,
  input  logic                      out_ready_in,
  output logic [7:0]                drop_count_out,
  output logic [2:0]                state_out
);

  // state   | meaning
  // IDLE    | stopped, waiting for enable_in
  // ARM     | waiting for frame start to restart the detector
  // CAPTURE | detector running, waiting for frame end
  // LATCH   | one cycle: snapshot detector results, update lock
  // PRESENT | snapshot offered to consumer until handshake
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_LATCH   = 3'd3,
    S_PRESENT = 3'd4
  } state_e;

  localparam logic [XW-1:0] H_LAST   = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(SCREEN_HEIGHT - 1);
  localparam logic [3:0]    LOCK_MAX = 4'(LOCK_FRAMES);

  state_e state_q, state_d;

  logic                      out_valid_q;
  logic [7:0]                drop_q;
  logic [NUM_TARGETS*XW-1:0] tgt_x_q, tgt_x_d;
  logic [NUM_TARGETS*YW-1:0] tgt_y_q, tgt_y_d;
  logic [NUM_TARGETS*YW-1:0] tgt_diam_q, tgt_diam_d;
  logic [NUM_TARGETS-1:0]    tgt_valid_q;
  logic [NUM_TARGETS-1:0]    tgt_lock_q, tgt_lock_d;
  logic [NUM_TARGETS*4-1:0]  lock_cnt_q, lock_cnt_d;

  logic sof, eof, handshake;

  assign sof       = (hcount_in == '0) && (vcount_in == '0);
  assign eof       = (hcount_in == H_LAST) && (vcount_in == V_LAST);
  assign handshake = out_valid_q & out_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable_in) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable_in) state_d = S_IDLE;
        else if (sof)   state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!enable_in) state_d = S_IDLE;
        else if (eof)   state_d = S_LATCH;
      end
      S_LATCH: begin
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        // a same-cycle frame start loses to the handshake; the detector restarts next frame
        if (handshake) state_d = enable_in ? S_ARM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    det_start_out = 1'b0;
    if (state_q == S_ARM && enable_in && sof) det_start_out = 1'b1;
  end

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_slot
    logic [3:0] cnt_cur;
    logic [3:0] cnt_upd;

    assign cnt_cur = lock_cnt_q[g*4 +: 4];

    always_comb begin
      cnt_upd = 4'd0;
      if (det_valid_in[g]) begin
        cnt_upd = (cnt_cur >= LOCK_MAX) ? LOCK_MAX : cnt_cur + 4'd1;
      end
    end

    assign lock_cnt_d[g*4 +: 4] = cnt_upd;
    assign tgt_lock_d[g]        = (cnt_upd == LOCK_MAX);

`ifdef TARGET_AVG_EN
    logic          avg_sel;
    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;
    logic [YW:0]   sum_d;

    // smoothing keys off the lock flag from before this frame's update
    assign avg_sel = det_valid_in[g] & tgt_lock_q[g];
    assign sum_x   = {1'b0, tgt_x_q[g*XW +: XW]}    + {1'b0, det_x_in[g*XW +: XW]};
    assign sum_y   = {1'b0, tgt_y_q[g*YW +: YW]}    + {1'b0, det_y_in[g*YW +: YW]};
    assign sum_d   = {1'b0, tgt_diam_q[g*YW +: YW]} + {1'b0, det_diam_in[g*YW +: YW]};

    assign tgt_x_d[g*XW +: XW]    = avg_sel ? sum_x[XW:1] : det_x_in[g*XW +: XW];
    assign tgt_y_d[g*YW +: YW]    = avg_sel ? sum_y[YW:1] : det_y_in[g*YW +: YW];
    assign tgt_diam_d[g*YW +: YW] = avg_sel ? sum_d[YW:1] : det_diam_in[g*YW +: YW];
`else
    assign tgt_x_d[g*XW +: XW]    = det_x_in[g*XW +: XW];
    assign tgt_y_d[g*YW +: YW]    = det_y_in[g*YW +: YW];
    assign tgt_diam_d[g*YW +: YW] = det_diam_in[g*YW +: YW];
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_valid_q <= 1'b0;
      drop_q      <= 8'd0;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      tgt_diam_q  <= '0;
      tgt_valid_q <= '0;
      tgt_lock_q  <= '0;
      lock_cnt_q  <= '0;
    end else begin
      // PRESENT is only ever entered from LATCH, so valid rises the cycle after LATCH
      out_valid_q <= (state_d == S_PRESENT);
      if (state_q == S_PRESENT && !handshake && sof && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
      if (state_q == S_LATCH) begin
        tgt_x_q     <= tgt_x_d;
        tgt_y_q     <= tgt_y_d;
        tgt_diam_q  <= tgt_diam_d;
        tgt_valid_q <= det_valid_in;
        tgt_lock_q  <= tgt_lock_d;
        lock_cnt_q  <= lock_cnt_d;
      end
    end
  end

  assign out_valid_out  = out_valid_q;
  assign drop_count_out = drop_q;
  assign tgt_x_out      = tgt_x_q;
  assign tgt_y_out      = tgt_y_q;
  assign tgt_diam_out   = tgt_diam_q;
  assign tgt_valid_out  = tgt_valid_q;
  assign tgt_lock_out   = tgt_lock_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_target_frame_ctrl.sv
// Directed bench for target_frame_ctrl: frame sequencing, lock tracking, drops, reset, disable.
// Define TARGET_AVG_EN for both bench and RTL to check the averaging build.
module tb_target_frame_ctrl;
  localparam int NT = 4;
  localparam int XW = 11;
  localparam int YW = 11;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            enable_in;
  logic [XW-1:0]   hcount_in;
  logic [YW-1:0]   vcount_in;
  logic [NT*XW-1:0] det_x_in;
  logic [NT*YW-1:0] det_y_in;
  logic [NT*YW-1:0] det_diam_in;
  logic [NT-1:0]   det_valid_in;
  logic            det_start_out;
  logic [NT*XW-1:0] tgt_x_out;
  logic [NT*YW-1:0] tgt_y_out;
  logic [NT*YW-1:0] tgt_diam_out;
  logic [NT-1:0]   tgt_valid_out;
  logic [NT-1:0]   tgt_lock_out;
  logic            out_valid_out;
  logic            out_ready_in;
  logic [7:0]      drop_count_out;
  logic [2:0]      state_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  target_frame_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .det_x_in       (det_x_in),
    .det_y_in       (det_y_in),
    .det_diam_in    (det_diam_in),
    .det_valid_in   (det_valid_in),
    .det_start_out  (det_start_out),
    .tgt_x_out      (tgt_x_out),
    .tgt_y_out      (tgt_y_out),
    .tgt_diam_out   (tgt_diam_out),
    .tgt_valid_out  (tgt_valid_out),
    .tgt_lock_out   (tgt_lock_out),
    .out_valid_out  (out_valid_out),
    .out_ready_in   (out_ready_in),
    .drop_count_out (drop_count_out),
    .state_out      (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #2;
  endtask

  task automatic set_pos(input int h, input int v);
    hcount_in = XW'(h);
    vcount_in = YW'(v);
  endtask

  // entered in ARM; leaves the DUT in PRESENT with the frame latched
  task automatic do_frame(input logic [3:0] v, input logic [XW-1:0] x0);
    det_valid_in   = v;
    det_x_in       = '0;
    det_x_in[10:0] = x0;
    det_y_in       = '0;
    det_diam_in    = '0;
    set_pos(0, 0);       tick;
    set_pos(5, 5);       tick;
    set_pos(1279, 719);  tick;
    set_pos(5, 5);       tick;
  endtask

  task automatic accept;
    out_ready_in = 1'b1;
    tick;
    out_ready_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_in = 1'b0; enable_in = 1'b0; out_ready_in = 1'b0;
    det_x_in = '0; det_y_in = '0; det_diam_in = '0; det_valid_in = '0;
    set_pos(5, 5);
    tick; tick;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_out); else pass_cnt++;
    chk_cnt++; if (out_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid_out); else pass_cnt++;
    chk_cnt++; if (drop_count_out !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_count_out); else pass_cnt++;
    chk_cnt++; if ({tgt_valid_out, tgt_lock_out} !== 8'h00) $display("FAIL reset_flags: got %h want 00", {tgt_valid_out, tgt_lock_out}); else pass_cnt++;
    rst_in = 1'b1;
    tick;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state_out); else pass_cnt++;
  endtask

  task automatic test_basic;
    enable_in = 1'b1;
    tick;
    chk_cnt++; if (state_out !== 3'd1) $display("FAIL basic_arm: got %0d want 1", state_out); else pass_cnt++;
    det_valid_in = 4'b0101; det_x_in = '0; det_x_in[10:0] = 11'd100;
    set_pos(0, 0); #1;
    chk_cnt++; if (det_start_out !== 1'b1) $display("FAIL basic_start: got %b want 1", det_start_out); else pass_cnt++;
    tick; set_pos(5, 5); #1;
    chk_cnt++; if (det_start_out !== 1'b0) $display("FAIL basic_start_once: got %b want 0", det_start_out); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd2) $display("FAIL basic_capture: got %0d want 2", state_out); else pass_cnt++;
    tick; set_pos(1279, 719);
    tick; set_pos(5, 5);
    chk_cnt++; if (out_valid_out !== 1'b0) $display("FAIL basic_valid_eof1: got %b want 0", out_valid_out); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd3) $display("FAIL basic_latch: got %0d want 3", state_out); else pass_cnt++;
    tick;
    chk_cnt++; if (out_valid_out !== 1'b1) $display("FAIL basic_valid_eof2: got %b want 1", out_valid_out); else pass_cnt++;
    chk_cnt++; if (tgt_x_out[10:0] !== 11'd100) $display("FAIL basic_x0: got %0d want 100", tgt_x_out[10:0]); else pass_cnt++;
    chk_cnt++; if (tgt_valid_out !== 4'b0101) $display("FAIL basic_tvalid: got %b want 0101", tgt_valid_out); else pass_cnt++;
    chk_cnt++; if (tgt_lock_out !== 4'b0000) $display("FAIL basic_lock: got %b want 0000", tgt_lock_out); else pass_cnt++;
    accept;
    chk_cnt++; if (out_valid_out !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid_out); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd1) $display("FAIL basic_rearm: got %0d want 1", state_out); else pass_cnt++;
  endtask

  task automatic test_lock;
    logic [3:0] exp_lock [5];
    logic [3:0] vin [5];
    vin[0] = 4'b0100; vin[1] = 4'b0100; vin[2] = 4'b0100; vin[3] = 4'b0100; vin[4] = 4'b0000;
    exp_lock[0] = 4'b0000; exp_lock[1] = 4'b0000; exp_lock[2] = 4'b0100;
    exp_lock[3] = 4'b0100; exp_lock[4] = 4'b0000;
    do_frame(4'b0000, 11'd0);  // clears counts left by the basic frame
    accept;
    for (int f = 0; f < 5; f++) begin
      do_frame(vin[f], 11'd0);
      chk_cnt++;
      if (tgt_lock_out !== exp_lock[f]) $display("FAIL lock_f%0d: got %b want %b", f, tgt_lock_out, exp_lock[f]);
      else pass_cnt++;
      accept;
    end
  endtask

  task automatic test_drop;
    do_frame(4'b0011, 11'd321);
    for (int k = 0; k < 3; k++) begin
      det_x_in[10:0] = 11'd999; det_valid_in = 4'b1111;
      set_pos(0, 0); #1;
      chk_cnt++; if (det_start_out !== 1'b0) $display("FAIL drop_nostart%0d: got %b want 0", k, det_start_out); else pass_cnt++;
      tick; set_pos(5, 5); tick;
    end
    chk_cnt++; if (drop_count_out !== 8'd3) $display("FAIL drop_count: got %0d want 3", drop_count_out); else pass_cnt++;
    chk_cnt++; if (out_valid_out !== 1'b1) $display("FAIL drop_valid: got %b want 1", out_valid_out); else pass_cnt++;
    chk_cnt++; if (tgt_x_out[10:0] !== 11'd321) $display("FAIL drop_x0: got %0d want 321", tgt_x_out[10:0]); else pass_cnt++;
    chk_cnt++; if (tgt_valid_out !== 4'b0011) $display("FAIL drop_tvalid: got %b want 0011", tgt_valid_out); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd4) $display("FAIL drop_state: got %0d want 4", state_out); else pass_cnt++;
    accept;
    chk_cnt++; if (drop_count_out !== 8'd3) $display("FAIL drop_hold: got %0d want 3", drop_count_out); else pass_cnt++;
    do_frame(4'b1000, 11'd77);
    chk_cnt++; if (tgt_x_out[10:0] !== 11'd77) $display("FAIL drop_next_x0: got %0d want 77", tgt_x_out[10:0]); else pass_cnt++;
    chk_cnt++; if (tgt_valid_out !== 4'b1000) $display("FAIL drop_next_tvalid: got %b want 1000", tgt_valid_out); else pass_cnt++;
  endtask

  task automatic test_sof_handshake;
    out_ready_in = 1'b1; set_pos(0, 0); #1;
    chk_cnt++; if (det_start_out !== 1'b0) $display("FAIL hs_sof_nostart: got %b want 0", det_start_out); else pass_cnt++;
    tick; out_ready_in = 1'b0; set_pos(5, 5);
    chk_cnt++; if (state_out !== 3'd1) $display("FAIL hs_sof_arm: got %0d want 1", state_out); else pass_cnt++;
    chk_cnt++; if (drop_count_out !== 8'd3) $display("FAIL hs_sof_nodrop: got %0d want 3", drop_count_out); else pass_cnt++;
    chk_cnt++; if (out_valid_out !== 1'b0) $display("FAIL hs_sof_valid: got %b want 0", out_valid_out); else pass_cnt++;
    tick; #1;
    chk_cnt++; if (det_start_out !== 1'b0) $display("FAIL hs_wait_nostart: got %b want 0", det_start_out); else pass_cnt++;
    set_pos(0, 0); #1;
    chk_cnt++; if (det_start_out !== 1'b1) $display("FAIL hs_next_start: got %b want 1", det_start_out); else pass_cnt++;
    tick; set_pos(5, 5);
    chk_cnt++; if (state_out !== 3'd2) $display("FAIL hs_capture: got %0d want 2", state_out); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    chk_cnt++; if (tgt_x_out[10:0] !== 11'd77) $display("FAIL rst_pre_x0: got %0d want 77", tgt_x_out[10:0]); else pass_cnt++;
    rst_in = 1'b0; #1;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL rst_cap_state: got %0d want 0", state_out); else pass_cnt++;
    chk_cnt++; if (tgt_x_out !== '0) $display("FAIL rst_cap_x: got %h want 0", tgt_x_out); else pass_cnt++;
    chk_cnt++; if (tgt_valid_out !== 4'b0000) $display("FAIL rst_cap_tvalid: got %b want 0000", tgt_valid_out); else pass_cnt++;
    chk_cnt++; if (drop_count_out !== 8'd0) $display("FAIL rst_cap_drop: got %0d want 0", drop_count_out); else pass_cnt++;
    tick; rst_in = 1'b1;
    tick;
    do_frame(4'b0010, 11'd55);
    chk_cnt++; if (out_valid_out !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", out_valid_out); else pass_cnt++;
    rst_in = 1'b0; #1;
    chk_cnt++; if (out_valid_out !== 1'b0) $display("FAIL rst_pres_valid: got %b want 0", out_valid_out); else pass_cnt++;
    chk_cnt++; if (tgt_valid_out !== 4'b0000) $display("FAIL rst_pres_tvalid: got %b want 0000", tgt_valid_out); else pass_cnt++;
    tick; rst_in = 1'b1;
    tick;
  endtask

  task automatic test_disable_avg;
    logic [10:0] exp_x;
`ifdef TARGET_AVG_EN
    exp_x = 11'd205;
`else
    exp_x = 11'd210;
`endif
    do_frame(4'b0001, 11'd200);
    accept;
    set_pos(0, 0); tick;
    enable_in = 1'b0; set_pos(5, 5); tick;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL dis_capture_idle: got %0d want 0", state_out); else pass_cnt++;
    enable_in = 1'b1; tick;
    do_frame(4'b0001, 11'd200);
    chk_cnt++; if (tgt_lock_out !== 4'b0000) $display("FAIL dis_lock2: got %b want 0000", tgt_lock_out); else pass_cnt++;
    accept;
    do_frame(4'b0001, 11'd200);
    chk_cnt++; if (tgt_lock_out !== 4'b0001) $display("FAIL dis_lock_kept: got %b want 0001", tgt_lock_out); else pass_cnt++;
    chk_cnt++; if (tgt_x_out[10:0] !== 11'd200) $display("FAIL avg_pre_x0: got %0d want 200", tgt_x_out[10:0]); else pass_cnt++;
    accept;
    do_frame(4'b0001, 11'd210);
    chk_cnt++; if (tgt_x_out[10:0] !== exp_x) $display("FAIL avg_x0: got %0d want %0d", tgt_x_out[10:0], exp_x); else pass_cnt++;
    enable_in = 1'b0; tick;
    chk_cnt++; if (state_out !== 3'd4) $display("FAIL dis_present_hold: got %0d want 4", state_out); else pass_cnt++;
    chk_cnt++; if (out_valid_out !== 1'b1) $display("FAIL dis_present_valid: got %b want 1", out_valid_out); else pass_cnt++;
    accept;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL dis_hs_idle: got %0d want 0", state_out); else pass_cnt++;
    chk_cnt++; if (out_valid_out !== 1'b0) $display("FAIL dis_hs_valid: got %b want 0", out_valid_out); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lock;
    test_drop;
    test_sof_handshake;
    test_async_reset;
    test_disable_avg;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
